// File: rtl/alu_iterative_pkg.sv
// Shared definitions for the iterative ALU: opcode and FSM state encodings.
package alu_iterative_pkg;

  localparam int unsigned AluWidth = 8;

  typedef enum logic [2:0] {
    AluFwd  = 3'b000,
    AluAdd  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluMult = 3'b100,
    AluSll  = 3'b101,
    AluSrl  = 3'b110,
    AluSra  = 3'b111
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

endpackage

// File: rtl/alu_iter_datapath.sv
// Multi-cycle datapath: shift-and-add multiplier and one-bit-per-step shifter.
module alu_iter_datapath
  import alu_iterative_pkg::*;
#(
  parameter int unsigned WIDTH      = AluWidth,
  parameter int unsigned MUL_CYCLES = AluWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic             last
);

  localparam int unsigned CountWidth = $clog2(MUL_CYCLES + 1);

  alu_op_e               op_q;
  logic [WIDTH-1:0]      acc_q, mcand_q, mplier_q, acc_step;
  logic [CountWidth-1:0] count_q, count_load;

  // Shift amounts saturate at WIDTH: further steps could not change the result.
  always_comb begin
    count_load = CountWidth'(MUL_CYCLES);
    if (is_shift(op)) begin
      count_load = (b >= WIDTH'(WIDTH)) ? CountWidth'(WIDTH) : CountWidth'(b);
    end
  end

  always_comb begin
    acc_step = acc_q;
    case (op_q)
      AluMult: if (mplier_q[0]) acc_step = acc_q + mcand_q;
      AluSll:  acc_step = {acc_q[WIDTH-2:0], 1'b0};
      AluSrl:  acc_step = {1'b0, acc_q[WIDTH-1:1]};
      AluSra:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= AluFwd;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      op_q     <= op;
      acc_q    <= (op == AluMult) ? '0 : a;
      mcand_q  <= a;
      mplier_q <= b;
      count_q  <= count_load;
    end else if (step) begin
      acc_q    <= acc_step;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      count_q  <= count_q - 1'b1;
    end
  end

  assign acc_next = acc_step;
  assign last     = (count_q == CountWidth'(1));

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/add ops, iterative multiply and shifts.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int unsigned WIDTH      = AluWidth,
  parameter int unsigned MUL_CYCLES = AluWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, single_res, acc_next;
  logic             done_q, done_d, load, step, last;
  alu_op_e          op;

  assign op = alu_op_e'(aluop);

  alu_iter_datapath #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .op       (op),
    .a        (data1),
    .b        (data2),
    .acc_next (acc_next),
    .last     (last)
  );

  // DATA2 arrives already negated for SUB, so ADD covers both.
  always_comb begin
    single_res = data1;
    case (op)
      AluFwd:  single_res = data2;
      AluAdd:  single_res = data1 + data2;
      AluAnd:  single_res = data1 & data2;
      AluOr:   single_res = data1 | data2;
      default: single_res = data1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == AluMult || (is_shift(op) && data2 != '0)) begin
            load    = 1'b1;
            state_d = StRun;
          end else begin
            result_d = single_res;
            done_d   = 1'b1;
          end
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) begin
          result_d = acc_next;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);
  assign busy   = (state_q == StRun);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: directed ops, results checked on every DONE pulse.
module tb_alu_iterative;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] aluop = 3'b000;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic [7:0] result;
  logic       zero, busy, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  alu_iterative u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluop  (aluop),
    .data1  (data1),
    .data2  (data2),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: each DONE pulse consumes one expected result.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result 0x%0h, expected no DONE", result);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("result", int'(result), int'(e));
        check("zero", int'(zero), int'(e == 8'h00));
      end
    end
  end

  // Issue one op at the next edge, then count cycles BUSY stays high.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input int exp_busy, input string name);
    int n = 0;
    @(posedge clk); #1;
    start = 1'b1; aluop = op; data1 = a; data2 = b;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    start = 1'b0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check({name, "_busy_cycles"}, n, exp_busy);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_zero", int'(zero), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    #1 reset = 1'b1;

    run_op(3'b001, 8'h05, 8'hFB, 8'h00, 0, "sub_zero");
    run_op(3'b001, 8'h0A, 8'hFB, 8'h05, 0, "sub_nonzero");
    run_op(3'b100, 8'h05, 8'h07, 8'h23, 8, "mult_5x7");
    run_op(3'b100, 8'h0D, 8'h14, 8'h04, 8, "mult_trunc");
    run_op(3'b111, 8'h90, 8'h03, 8'hF2, 3, "sra_3");
    run_op(3'b101, 8'h81, 8'h09, 8'h00, 8, "sll_9");
    run_op(3'b110, 8'hA5, 8'h00, 8'hA5, 0, "srl_0");
    run_op(3'b111, 8'h80, 8'h0C, 8'hFF, 8, "sra_12");
    run_op(3'b010, 8'hF0, 8'h3C, 8'h30, 0, "and");
    run_op(3'b011, 8'hF0, 8'h0C, 8'hFC, 0, "or");

    // START while busy must be ignored; inputs may change during RUN.
    @(posedge clk); #1;
    start = 1'b1; aluop = 3'b100; data1 = 8'h03; data2 = 8'h03;
    exp_q.push_back(8'h09);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; aluop = 3'b001; data1 = 8'h01; data2 = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_ignore_cycles", n, 8);
    repeat (3) @(posedge clk);

    // Reset in the middle of a multiply: no result, no DONE.
    @(posedge clk); #1;
    start = 1'b1; aluop = 3'b100; data1 = 8'hFF; data2 = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset_result", int'(result), 0);
    check("midreset_zero", int'(zero), 1);
    check("midreset_busy", int'(busy), 0);
    repeat (10) @(posedge clk);

    run_op(3'b001, 8'h01, 8'h02, 8'h03, 0, "add_after_reset");
    repeat (3) @(posedge clk);
    check("pending_results", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute stage that consumes the operand selected by the subtraction mux and immediate mux (DATA2) and the register-file operand (DATA1).
- Produces a registered 8-bit RESULT, a ZERO flag for branches, and a BUSY stall to the PC/control unit.
- Forward, ADD (also SUB, since DATA2 already arrives two's-complemented), AND and OR complete in one cycle.
- MULT and the shifts are iterative, one step per clock.

Parameters:
- WIDTH, 8, operand/result width.
- MUL_CYCLES, 8, iterations for MULT (equals WIDTH).

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  launch operation; sampled only when BUSY=0.
- ALUOP  input  3  000 FWD, 001 ADD, 010 AND, 011 OR, 100 MULT, 101 SLL, 110 SRL, 111 SRA.
- DATA1  input  8  register operand (REGOUT1); shift source for shifts.
- DATA2  input  8  second operand; unsigned shift amount for shifts.
- RESULT  output  8  registered result.
- ZERO  output  1  combinational, (RESULT == 0).
- BUSY  output  1  high while an iterative op is in progress.
- DONE  output  1  one-cycle pulse when RESULT has just been updated.

Behaviour:
- Reset (RESET=0 at a rising edge) forces RESULT=0x00, BUSY=0, DONE=0, FSM=IDLE and internal operand/counter registers to 0. ZERO therefore reads 1.
- Reset has priority over everything, including mid-operation; no partial result is written.
- FSM states: IDLE, RUN.
- IDLE with START=1, single-cycle op (FWD, ADD, AND, OR, or a shift with DATA2==0):
  - At that edge RESULT gets the op result; DATA1 is passed through for a zero-amount shift.
  - DONE=1 for the following cycle; BUSY stays 0.
- IDLE with START=1 and MULT:
  - Latch DATA1/DATA2, set count=MUL_CYCLES, BUSY=1, go to RUN.
  - Each RUN edge does shift-and-add (acc += mcand if mplier[0]; mcand<<=1; mplier>>=1).
  - At the 8th RUN edge, RESULT = acc[7:0] (upper bits discarded, no overflow flag), BUSY=0, DONE=1 for the next cycle, return to IDLE.
  - Total: START edge E0, RESULT/DONE at edge E0+8.
- IDLE with START=1 and a shift with DATA2 ≥ 1:
  - count = min(DATA2, 8).
  - Each RUN edge shifts 1 bit: SLL fills 0 on the right, SRL fills 0 on the left, SRA replicates bit 7.
  - Completes at edge E0+count as above. Amounts ≥ 8 give 0x00 (SLL/SRL) or 0x00/0xFF (SRA).
- RESULT holds its previous value throughout RUN and updates only at completion.
- START while BUSY=1 is ignored, with no queuing. The ALUOP/DATA inputs may change freely during RUN because operands are latched.
- START asserted in the same cycle DONE is high is accepted (back-to-back ops allowed).
- ADD wraps modulo 256 with no carry/overflow outputs.
- DONE never lasts more than one cycle.
- BUSY is registered and low in IDLE.

Decomposition:
- Shared header alu_defs: ALUOP encodings (ALU_FWD … ALU_SRA), FSM state encodings (S_IDLE, S_RUN), WIDTH default. The control unit and this block both include it.
- One natural sub-module, alu_iter_datapath: holds the acc/mcand/mplier/count registers and the one-step shift/add logic, controlled by load/step signals.
- The FSM, single-cycle ops and RESULT/DONE registers stay in alu_iterative.

Test Plan:
- Reset then idle: RESET=0 for 2 cycles → RESULT=0x00, ZERO=1, BUSY=0, DONE=0.
- ADD as SUB: DATA1=0x05, DATA2=0xFB, ALUOP=001, START pulse → next cycle RESULT=0x00, ZERO=1, DONE=1, BUSY never high. Repeat with DATA1=0x0A → RESULT=0x05, ZERO=0.
- MULT: DATA1=0x05, DATA2=0x07 → BUSY high exactly 8 cycles, RESULT=0x23 at edge E0+8, single DONE pulse. Then 0x0D×0x14 → RESULT=0x04 (260 truncated).
- Shifts:
  - SRA DATA1=0x90, DATA2=0x03 → BUSY 3 cycles, RESULT=0xF2.
  - SLL DATA1=0x81, DATA2=0x09 → 8 cycles, RESULT=0x00.
  - SRL DATA2=0x00 → single cycle, RESULT=DATA1.
- START during BUSY: launch MULT 3×3, pulse START with ADD at cycle 4 → ignored, RESULT=0x09 at E0+8, exactly one DONE.
- Reset mid-MULT: RESET=0 at cycle 5 of MULT 0xFF×0xFF → RESULT=0x00, BUSY=0, DONE never pulses. The next ADD 0x01+0x02 → 0x03.
